// File: rtl/pc_sequencer.sv
// Program-counter stage: advances or branches the PC and converts DELAY instructions into
// a delayEn request. It then holds the PC until the external delay counter releases pcEn.
module pc_sequencer #(
   parameter int unsigned         PC_WIDTH     = 8,
   parameter int unsigned         INSTR_WIDTH  = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
   parameter logic [3:0]          DELAY_OPCODE = 4'hF,
   parameter int unsigned         ACK_TIMEOUT  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   instrValid,
   input  logic                   branchEn,
   input  logic [PC_WIDTH-1:0]    branchTarget,
   input  logic                   pcEn,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   delayEn,
   output logic                   stalled,
   output logic                   timeoutErr
);

   localparam int unsigned        CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]   ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_REQ,
      ST_WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] ack_cnt;
   logic [3:0]       opcode;
   logic             is_delay;

   assign opcode   = instr[INSTR_WIDTH-1 -: 4];
   assign is_delay = instrValid && (opcode == DELAY_OPCODE);

   // Only the opcode field steers this stage; the operand bits belong to later stages.
   logic unused_operand;
   assign unused_operand = ^instr[INSTR_WIDTH-5:0];

   // NOTE: every state register is written with <= so that all of them update from
   // the same pre-edge values, whatever order the statements below appear in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         pc         <= RESET_PC;
         delayEn    <= 1'b0;
         stalled    <= 1'b0;
         timeoutErr <= 1'b0;
         ack_cnt    <= '0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (pcEn) begin
                  if (branchEn) begin
                     pc <= branchTarget;
                  end else if (is_delay) begin
                     pc      <= pc + 1'b1;
                     delayEn <= 1'b1;
                     stalled <= 1'b1;
                     ack_cnt <= '0;
                     state   <= ST_REQ;
                  end else if (instrValid) begin
                     pc <= pc + 1'b1;
                  end
               end
            end

            ST_REQ: begin
               ack_cnt <= ack_cnt + 1'b1;
               // pcEn falling is the counter's acknowledge and takes precedence over timeout.
               if (!pcEn) begin
                  delayEn <= 1'b0;
                  state   <= ST_WAIT;
               end else if (ack_cnt == ACK_LAST) begin
                  timeoutErr <= 1'b1;
                  delayEn    <= 1'b0;
                  stalled    <= 1'b0;
                  state      <= ST_RUN;
               end
            end

            ST_WAIT: begin
               if (pcEn) begin
                  stalled <= 1'b0;
                  state   <= ST_RUN;
               end
            end

            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer, with every output checked each cycle
// against a behavioural model of the request/acknowledge protocol.
module tb_pc_sequencer;

   localparam int         PC_WIDTH    = 8;
   localparam int         INSTR_WIDTH = 16;
   localparam int         ACK_TIMEOUT = 4;
   localparam logic [3:0] DELAY_OP    = 4'hF;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [INSTR_WIDTH-1:0] instr;
   logic                   instrValid;
   logic                   branchEn;
   logic [PC_WIDTH-1:0]    branchTarget;
   logic                   pcEn;
   logic [PC_WIDTH-1:0]    pc;
   logic                   delayEn;
   logic                   stalled;
   logic                   timeoutErr;

   int tests = 0;
   int fails = 0;

   // Reference model: a pending request ages until acknowledged or timed out,
   // and an acknowledged request waits for the release.
   logic [PC_WIDTH-1:0] m_pc;
   bit                  m_delay, m_stalled, m_err;
   bit                  m_requesting, m_waiting;
   int                  m_req_age;

   always #5 clk = ~clk;

   pc_sequencer #(
      .PC_WIDTH     (PC_WIDTH),
      .INSTR_WIDTH  (INSTR_WIDTH),
      .RESET_PC     (8'h00),
      .DELAY_OPCODE (DELAY_OP),
      .ACK_TIMEOUT  (ACK_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .instrValid   (instrValid),
      .branchEn     (branchEn),
      .branchTarget (branchTarget),
      .pcEn         (pcEn),
      .pc           (pc),
      .delayEn      (delayEn),
      .stalled      (stalled),
      .timeoutErr   (timeoutErr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc         = 8'h00;
      m_delay      = 1'b0;
      m_stalled    = 1'b0;
      m_err        = 1'b0;
      m_requesting = 1'b0;
      m_waiting    = 1'b0;
      m_req_age    = 0;
   endtask

   task automatic model_update();
      if (m_requesting) begin
         if (!pcEn) begin
            m_requesting = 1'b0;
            m_waiting    = 1'b1;
            m_delay      = 1'b0;
         end else if (m_req_age == ACK_TIMEOUT - 1) begin
            m_requesting = 1'b0;
            m_err        = 1'b1;
            m_delay      = 1'b0;
            m_stalled    = 1'b0;
         end else begin
            m_req_age++;
         end
      end else if (m_waiting) begin
         if (pcEn) begin
            m_waiting = 1'b0;
            m_stalled = 1'b0;
         end
      end else if (pcEn) begin
         if (branchEn) begin
            m_pc = branchTarget;
         end else if (instrValid && instr[15:12] == DELAY_OP) begin
            m_pc         = m_pc + 8'd1;
            m_delay      = 1'b1;
            m_stalled    = 1'b1;
            m_requesting = 1'b1;
            m_req_age    = 0;
         end else if (instrValid) begin
            m_pc = m_pc + 8'd1;
         end
      end
   endtask

   task automatic drive(input bit valid, input logic [3:0] op, input bit br,
                        input logic [7:0] tgt, input bit pen);
      instrValid   = valid;
      instr        = {op, 12'($urandom)};
      branchEn     = br;
      branchTarget = tgt;
      pcEn         = pen;
   endtask

   task automatic drive_rand(input bit pen);
      logic [3:0] op;
      op = ($urandom_range(3) == 0) ? DELAY_OP : 4'($urandom_range(14));
      drive(1'($urandom), op, ($urandom_range(7) == 0), 8'($urandom), pen);
   endtask

   // One clock: the model consumes the inputs the DUT sampled, then outputs are compared.
   task automatic step(input string tag);
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_update();
      #1;
      check({tag, "_pc"},         pc,         m_pc);
      check({tag, "_delayEn"},    delayEn,    m_delay);
      check({tag, "_stalled"},    stalled,    m_stalled);
      check({tag, "_timeoutErr"}, timeoutErr, m_err);
   endtask

   initial begin
      int hi;
      model_reset();
      drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
      rst_n = 1'b0;
      repeat (2) step("reset");
      check("reset_pc", pc, 8'h00);
      check("reset_stalled", stalled, 1'b0);
      rst_n = 1'b1;

      // Straight-line execution
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 4'h1, 1'b0, 8'h00, 1'b1);
         step("t1");
         check("t1_pc_step", pc, i);
      end

      // pc wraps from all-ones to zero
      drive(1'b0, 4'h0, 1'b1, 8'hFF, 1'b1);
      step("t2_br");
      check("t2_pc_ff", pc, 8'hFF);
      drive(1'b1, 4'h2, 1'b0, 8'h00, 1'b1);
      step("t2_wrap");
      check("t2_pc_wrap", pc, 8'h00);

      // DELAY at pc=3, acked two cycles after the request, released 20 cycles later
      drive(1'b0, 4'h0, 1'b1, 8'h03, 1'b1);
      step("t3_br");
      check("t3_pc3", pc, 8'h03);
      drive(1'b1, DELAY_OP, 1'b0, 8'h00, 1'b1);
      step("t3_req");
      check("t3_pc4", pc, 8'h04);
      hi = int'(delayEn);
      drive_rand(1'b1);
      step("t3_req2");
      hi += int'(delayEn);
      drive_rand(1'b0);
      step("t3_ack");
      hi += int'(delayEn);
      check("t3_delay_width", hi, 2);
      for (int i = 0; i < 19; i++) begin
         drive_rand(1'b0);
         step("t3_wait");
      end
      check("t3_still_stalled", stalled, 1'b1);
      check("t3_pc_held", pc, 8'h04);
      drive_rand(1'b1);
      step("t3_release");
      check("t3_unstalled", stalled, 1'b0);
      drive(1'b1, 4'h1, 1'b0, 8'h00, 1'b1);
      step("t3_resume");
      check("t3_pc5", pc, 8'h05);

      // Branch beats a DELAY opcode in the same cycle
      drive(1'b1, DELAY_OP, 1'b1, 8'h40, 1'b1);
      step("t4");
      check("t4_pc40", pc, 8'h40);
      check("t4_no_delay", delayEn, 1'b0);

      // Unacknowledged request times out
      drive(1'b1, DELAY_OP, 1'b0, 8'h00, 1'b1);
      step("t5_req");
      hi = int'(delayEn);
      for (int i = 0; i < ACK_TIMEOUT; i++) begin
         drive_rand(1'b1);
         step("t5_req");
         hi += int'(delayEn);
      end
      check("t5_delay_width", hi, ACK_TIMEOUT);
      check("t5_timeoutErr", timeoutErr, 1'b1);
      check("t5_run_again", stalled, 1'b0);
      check("t5_pc_held", pc, 8'h41);
      drive(1'b1, 4'h3, 1'b0, 8'h00, 1'b1);
      step("t5_next");
      check("t5_pc42", pc, 8'h42);
      check("t5_err_sticky", timeoutErr, 1'b1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive_rand($urandom_range(3) != 0);
         step("rand");
      end
      for (int i = 0; i < ACK_TIMEOUT + 2; i++) begin
         drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
         step("drain");
      end

      // Asynchronous reset while waiting for release
      drive(1'b1, DELAY_OP, 1'b0, 8'h00, 1'b1);
      step("t6_req");
      drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b0);
      step("t6_ack");
      step("t6_wait");
      check("t6_in_wait", stalled, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_async_pc", pc, 8'h00);
      check("t6_async_stalled", stalled, 1'b0);
      check("t6_async_delayEn", delayEn, 1'b0);
      check("t6_async_timeoutErr", timeoutErr, 1'b0);
      model_reset();
      step("t6_hold");
      rst_n = 1'b1;
      drive(1'b1, 4'h1, 1'b0, 8'h00, 1'b1);
      step("t6_run");
      check("t6_pc1", pc, 8'h01);
      drive(1'b1, DELAY_OP, 1'b0, 8'h00, 1'b1);
      step("t6_req_again");
      check("t6_new_req", delayEn, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
